// File: rtl/aes_128_axil_slave_if.sv
// AXI4-Lite slave bus bundle for the AES-128 register block.
// Channels: AW (awaddr/awprot/awvalid/awready), W (wdata/wstrb/wvalid/wready),
//           B (bresp/bvalid/bready), AR (araddr/arprot/arvalid/arready),
//           R (rdata/rresp/rvalid/rready).
// Modports: master drives requests, slave drives readies and responses.
interface aes_128_axil_slave_if #(
    parameter int unsigned C_S_AXI_DATA_WIDTH = 32,
    parameter int unsigned C_S_AXI_ADDR_WIDTH = 6
);
    localparam int unsigned STRB_W = C_S_AXI_DATA_WIDTH / 8;

    logic [C_S_AXI_ADDR_WIDTH-1:0] awaddr;
    logic [2:0]                    awprot;
    logic                          awvalid;
    logic                          awready;
    logic [C_S_AXI_DATA_WIDTH-1:0] wdata;
    logic [STRB_W-1:0]             wstrb;
    logic                          wvalid;
    logic                          wready;
    logic [1:0]                    bresp;
    logic                          bvalid;
    logic                          bready;
    logic [C_S_AXI_ADDR_WIDTH-1:0] araddr;
    logic [2:0]                    arprot;
    logic                          arvalid;
    logic                          arready;
    logic [C_S_AXI_DATA_WIDTH-1:0] rdata;
    logic [1:0]                    rresp;
    logic                          rvalid;
    logic                          rready;

    modport master (
        output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
        output araddr, arprot, arvalid, rready,
        input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

    modport slave (
        input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
        input  araddr, arprot, arvalid, rready,
        output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );
endinterface

// File: rtl/aes_128_axil_slave.sv
// AXI4-Lite register front end for an AES-128 core: KEY0-3 and PT0-3 (RW),
// CTRL.START, STATUS (BUSY, DONE W1C) and captured ciphertext CT0-3 (RO).
// Ports:
//   S_AXI_ACLK, S_AXI_ARESETN : clock, async active-low reset
//   s_axi                     : AXI4-Lite slave bus (aes_128_axil_slave_if.slave)
//   key_o, pt_o               : 128-bit key / plaintext to the core
//   start_o                   : one-cycle start pulse to the core
//   ct_i, core_done_i         : ciphertext and one-cycle completion pulse from the core
module aes_128_axil_slave #(
    parameter int unsigned C_S_AXI_DATA_WIDTH = 32,
    parameter int unsigned C_S_AXI_ADDR_WIDTH = 6
) (
    input  logic                       S_AXI_ACLK,
    input  logic                       S_AXI_ARESETN,
    aes_128_axil_slave_if.slave        s_axi,
    output logic [127:0]               key_o,
    output logic [127:0]               pt_o,
    output logic                       start_o,
    input  logic [127:0]               ct_i,
    input  logic                       core_done_i
);
    localparam int unsigned WORD_W = C_S_AXI_DATA_WIDTH;
    localparam int unsigned ADDR_W = C_S_AXI_ADDR_WIDTH;

    typedef enum logic {ST_IDLE, ST_BUSY} state_t;

    state_t              state, state_next;
    logic                start_req, core_fin, busy, done;
    logic [127:0]        ct;
    logic [ADDR_W-1:0]   wr_addr, rd_addr;
    logic [3:0]          wr_idx, rd_idx;
    logic                wr_en, rd_en;
    logic [WORD_W-1:0]   rd_word;
    logic [1:0]          ct_sel;
    logic                unused_bits;

    assign wr_addr = s_axi.awaddr;
    assign rd_addr = s_axi.araddr;
    assign wr_idx  = wr_addr[5:2];
    assign rd_idx  = rd_addr[5:2];
    assign wr_en   = s_axi.awready & s_axi.wready & s_axi.awvalid & s_axi.wvalid;
    assign rd_en   = s_axi.arready & s_axi.arvalid;
    assign busy    = (state == ST_BUSY);
    assign unused_bits = ^{s_axi.awprot, s_axi.arprot, wr_addr[1:0], rd_addr[1:0]};

    // Every access completes OKAY, reserved and read-only addresses included.
    assign s_axi.bresp = 2'b00;
    assign s_axi.rresp = 2'b00;

    // Operation state register.
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            state   <= ST_IDLE;
            start_o <= 1'b0;
        end else begin
            state   <= state_next;
            start_o <= start_req;
        end
    end

    // Start only from idle; completion only counts while an operation is running.
    always_comb begin
        state_next = state;
        start_req  = 1'b0;
        core_fin   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (wr_en && wr_idx == 4'd8 && s_axi.wdata[0]) begin
                    start_req  = 1'b1;
                    state_next = ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (core_done_i) begin
                    core_fin   = 1'b1;
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // DONE flag and ciphertext capture; a completion beats a same-cycle W1C.
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            done <= 1'b0;
            ct   <= '0;
        end else begin
            if (start_req) begin
                done <= 1'b0;
            end else if (core_fin) begin
                done <= 1'b1;
            end else if (wr_en && wr_idx == 4'd9 && s_axi.wdata[1]) begin
                done <= 1'b0;
            end
            if (core_fin) begin
                ct <= ct_i;
            end
        end
    end

    // KEY/PT byte-lane writes, frozen while the core is busy.
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            key_o <= '0;
            pt_o  <= '0;
        end else if (wr_en && !busy && !wr_idx[3]) begin
            for (int b = 0; b < 4; b++) begin
                if (s_axi.wstrb[b]) begin
                    if (wr_idx[2]) begin
                        pt_o[{wr_idx[1:0], 2'(b), 3'b000} +: 8] <= s_axi.wdata[8*b +: 8];
                    end else begin
                        key_o[{wr_idx[1:0], 2'(b), 3'b000} +: 8] <= s_axi.wdata[8*b +: 8];
                    end
                end
            end
        end
    end

    // Write channel: single-cycle AW/W accept, response held until BREADY.
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            s_axi.awready <= 1'b0;
            s_axi.wready  <= 1'b0;
            s_axi.bvalid  <= 1'b0;
        end else begin
            if (!s_axi.awready && !s_axi.wready && s_axi.awvalid && s_axi.wvalid && !s_axi.bvalid) begin
                s_axi.awready <= 1'b1;
                s_axi.wready  <= 1'b1;
            end else begin
                s_axi.awready <= 1'b0;
                s_axi.wready  <= 1'b0;
            end
            if (wr_en) begin
                s_axi.bvalid <= 1'b1;
            end else if (s_axi.bready) begin
                s_axi.bvalid <= 1'b0;
            end
        end
    end

    // Read data mux; sampled before any same-edge register update.
    always_comb begin
        rd_word = '0;
        ct_sel  = 2'(rd_idx - 4'd10);
        case (rd_idx)
            4'd0, 4'd1, 4'd2, 4'd3:     rd_word = key_o[{rd_idx[1:0], 5'b00000} +: 32];
            4'd4, 4'd5, 4'd6, 4'd7:     rd_word = pt_o[{rd_idx[1:0], 5'b00000} +: 32];
            4'd9:                       rd_word = {30'd0, done, busy};
            4'd10, 4'd11, 4'd12, 4'd13: rd_word = ct[{ct_sel, 5'b00000} +: 32];
            default:                    rd_word = '0;
        endcase
    end

    // Read channel: one-cycle ARREADY, RDATA/RVALID held until RREADY.
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            s_axi.arready <= 1'b0;
            s_axi.rvalid  <= 1'b0;
            s_axi.rdata   <= '0;
        end else begin
            s_axi.arready <= !s_axi.arready && s_axi.arvalid && !s_axi.rvalid;
            if (rd_en) begin
                s_axi.rvalid <= 1'b1;
                s_axi.rdata  <= rd_word;
            end else if (s_axi.rready) begin
                s_axi.rvalid <= 1'b0;
            end
        end
    end
endmodule

// File: doc/aes_128_axil_slave.md
AES_128_AXIL_SLAVE -- requirements
Module: aes_128_axil_slave

Interface
REQ-001 SHALL have parameter C_S_AXI_DATA_WIDTH, default 32, AXI4-Lite data width; only 32 is supported.
REQ-002 SHALL have parameter C_S_AXI_ADDR_WIDTH, default 6, byte address width.
REQ-003 S_AXI_ACLK  in  1  single clock; all logic rising-edge.
REQ-004 S_AXI_ARESETN  in  1  reset, asynchronous, active-low.
REQ-005 S_AXI_AWADDR/AWPROT/AWVALID/AWREADY  in/in/in/out  6/3/1/1  write address channel; AWPROT ignored.
REQ-006 S_AXI_WDATA/WSTRB/WVALID/WREADY  in/in/in/out  32/4/1/1  write data channel.
REQ-007 S_AXI_BRESP/BVALID/BREADY  out/out/in  2/1/1  write response.
REQ-008 S_AXI_ARADDR/ARPROT/ARVALID/ARREADY  in/in/in/out  6/3/1/1  read address; ARPROT ignored.
REQ-009 S_AXI_RDATA/RRESP/RVALID/RREADY  out/out/out/in  32/2/1/1  read data.
REQ-010 key_o  out  128  key to AES core; KEYn drives key_o[32n+31:32n].
REQ-011 pt_o  out  128  plaintext to core; PTn drives pt_o[32n+31:32n].
REQ-012 start_o  out  1  one-cycle start pulse to core.
REQ-013 ct_i  in  128  ciphertext from core, valid while core_done_i=1.
REQ-014 core_done_i  in  1  one-cycle completion pulse from core.

Function
REQ-015 Register map SHALL be decoded on addr[5:2]: 0x00-0x0C KEY0-3 RW; 0x10-0x1C PT0-3 RW; 0x20 CTRL (bit0 START, write-only, reads 0); 0x24 STATUS (bit0 BUSY RO, bit1 DONE W1C); 0x28-0x34 CT0-3 RO; 0x38-0x3C reserved (read 0, writes ignored).
REQ-016 Write accept: AWREADY and WREADY SHALL pulse high together for exactly one cycle when AWVALID=1, WVALID=1, BVALID=0 and neither ready is already high; the register update occurs in that same handshake cycle.
REQ-017 BVALID SHALL rise the cycle after the write handshake and hold until BREADY=1 is sampled; no new write is accepted while BVALID=1.
REQ-018 Read accept: ARREADY SHALL pulse one cycle when ARVALID=1 and RVALID=0; RVALID and RDATA SHALL be registered the next cycle and held stable until RREADY=1 is sampled.
REQ-019 BRESP and RRESP SHALL always be 2'b00 (OKAY), including reserved and RO addresses.
REQ-020 WSTRB[b]=1 SHALL update byte b only, for KEY and PT registers; WSTRB is ignored for CTRL and STATUS (bit decode only).
REQ-021 Writes to KEY/PT while BUSY=1 SHALL be ignored (still OKAY), so key_o and pt_o are stable for the whole operation.
REQ-022 Writing CTRL with WDATA[0]=1 while BUSY=0 SHALL assert start_o for exactly one cycle, starting the cycle after the handshake; BUSY SHALL set and DONE SHALL clear in the same cycle start_o is high.
REQ-023 START while BUSY=1 SHALL be ignored; no second start_o pulse.
REQ-024 On core_done_i=1 with BUSY=1: CT0-3 SHALL capture ct_i, BUSY SHALL clear and DONE SHALL set at that clock edge; core_done_i with BUSY=0 SHALL be ignored.
REQ-025 A STATUS write with WDATA[1]=1 SHALL clear DONE unless core_done_i sets it in the same cycle; set wins.
REQ-026 A read of CT0-3 in the core_done_i cycle SHALL return the previous CT value; the next read returns the new value.
REQ-027 Simultaneous read and write handshakes SHALL be independent; a read of a register written in the same cycle returns the pre-write value.

Reset
REQ-028 While S_AXI_ARESETN=0: AWREADY, WREADY, BVALID, ARREADY, RVALID, start_o = 0; RDATA = 0; KEY, PT, CT = 0; BUSY = DONE = 0.
REQ-029 Reset asserted mid-operation SHALL abandon any pending response and the operation; after release the block is idle, and a late core_done_i is ignored since BUSY=0.

Verification
REQ-030 Write 0x00000001..0x00000004 to 0x00-0x0C, read back -> 0x00000001..0x00000004 with RRESP=0; key_o=0x00000004_00000003_00000002_00000001.
REQ-031 Write KEY0=0xFFFFFFFF then KEY0=0x00000000 with WSTRB=4'b0101 -> read 0xFF00FF00.
REQ-032 Write CTRL=1 -> start_o single pulse, STATUS=0x1; model core pulses core_done_i with ct_i=0x3925841D_02DC09FB_DC118597_196A0B32 -> STATUS=0x2, CT3..CT0 read 0x3925841D, 0x02DC09FB, 0xDC118597, 0x196A0B32.
REQ-033 While BUSY: write PT0=0xDEADBEEF and CTRL=1 -> PT0 unchanged, no extra start_o, BRESP=OKAY for both.
REQ-034 Hold BREADY/RREADY low 5 cycles -> BVALID/RVALID and RDATA held stable, no further AWREADY/ARREADY pulse until the response completes.
REQ-035 Deassert S_AXI_ARESETN while BUSY=1 and BVALID=1 -> all outputs 0 immediately; after release, reads of KEY0 and STATUS return 0.
